// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// No logic, so no latency or backpressure of its own.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Wide enough for the largest legal read latency (15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin pick: combinational, zero latency.
// On a tie the port that did not win last time is chosen; no backpressure.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       valid
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter/sequencer for the data memory: grant+issue in T, done in T+MEM_LATENCY+1.
// Requesters are backpressured by withholding gnt until the block is back in IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               win_q, win_d;
    logic               we_q, we_d;
    logic               last_grant_q, last_grant_d;
    logic               p0_done_q, p0_done_d;
    logic               p1_done_q, p1_done_d;
    logic [DATA_W-1:0]  p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]  p1_rdata_q, p1_rdata_d;

    logic [1:0]         arb_grant;
    logic               arb_valid;
    logic               issue;
    logic               win;

    rr_arbiter2 u_rr (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Reset gates the issue path so nothing escapes to memory in a reset cycle.
    assign issue = !reset && (state_q == IDLE) && arb_valid;
    assign win   = arb_grant[PORT_AUX];

    assign p0_gnt    = issue && arb_grant[PORT_CPU];
    assign p1_gnt    = issue && arb_grant[PORT_AUX];
    assign mem_en    = issue;
    assign mem_we    = issue && (win ? p1_we : p0_we);
    assign mem_addr  = issue ? (win ? p1_addr : p0_addr) : '0;
    assign mem_wdata = issue ? (win ? p1_wdata : p0_wdata) : '0;

    assign p0_done  = p0_done_q;
    assign p1_done  = p1_done_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_d        = win_q;
        we_d         = we_q;
        last_grant_d = last_grant_q;
        p0_done_d    = 1'b0;
        p1_done_d    = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d      = WAIT;
                    cnt_d        = CNT_W'(MEM_LATENCY);
                    win_d        = win;
                    we_d         = mem_we;
                    last_grant_d = win;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // cnt==1 marks the cycle in which mem_rdata is valid.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    if (win_q == PORT_AUX) begin
                        p1_done_d = 1'b1;
                        if (!we_q) p1_rdata_d = mem_rdata;
                    end else begin
                        p0_done_d = 1'b1;
                        if (!we_q) p0_rdata_d = mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            win_q        <= PORT_CPU;
            we_q         <= 1'b0;
            last_grant_q <= PORT_AUX;
            p0_done_q    <= 1'b0;
            p1_done_q    <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
            p0_done_q    <= p0_done_d;
            p1_done_q    <= p1_done_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter at read latencies 2, 1 and 15, each lane with its own DUT,
// a transaction-level reference model and a directed + randomized stimulus script.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input int ln, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL lane%0d %s: got %0h want %0h (cycle %0d)", ln, name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int LAT      = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        localparam int DONE_OFS = (g == 0) ? 3 : ((g == 1) ? 2 : 16);
        localparam int SPACE    = (g == 0) ? 4 : ((g == 1) ? 3 : 17);

        logic        reset = 1'b1;
        logic        p0_req = 1'b0, p0_we = 1'b0;
        logic [31:0] p0_addr = '0, p0_wdata = '0;
        logic        p1_req = 1'b0, p1_we = 1'b0;
        logic [31:0] p1_addr = '0, p1_wdata = '0;
        logic [31:0] mem_rdata = '0;
        logic        p0_gnt, p0_done, p1_gnt, p1_done, mem_en, mem_we;
        logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
        bit          fin = 1'b0;

        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
            .clk       (clk),
            .reset     (reset),
            .p0_req    (p0_req),
            .p0_we     (p0_we),
            .p0_addr   (p0_addr),
            .p0_wdata  (p0_wdata),
            .p0_gnt    (p0_gnt),
            .p0_done   (p0_done),
            .p0_rdata  (p0_rdata),
            .p1_req    (p1_req),
            .p1_we     (p1_we),
            .p1_addr   (p1_addr),
            .p1_wdata  (p1_wdata),
            .p1_gnt    (p1_gnt),
            .p1_done   (p1_done),
            .p1_rdata  (p1_rdata),
            .mem_en    (mem_en),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata)
        );

        // Reference model: the block is "busy" until free_at; a grant schedules one completion.
        int          free_at = 0, done_cyc = -100, done_port = 0, issue_cyc = -100;
        bit          done_we = 1'b0, last = 1'b1, hold = 1'b0;
        logic [31:0] rd_val = '0, next_rd_val = '0;
        logic [31:0] mrd [2] = '{32'h0, 32'h0};

        // Observations of the DUT, used only to pace stimulus and for the directed checks.
        bit          g_seen [2] = '{1'b0, 1'b0};
        int          ngnt [2]   = '{0, 0};
        int          ndone [2]  = '{0, 0};
        int          gnt_o [2]  = '{0, 0};
        int          done_o [2] = '{0, 0};
        logic [31:0] g_addr = '0, g_wdata = '0;
        logic        g_we = 1'b0;
        int          gq [$];
        int          gc [$];

        initial begin : model
            int w;
            logic xwe;
            logic [31:0] xaddr, xwdata;
            forever begin
                @(negedge clk);
                w = -1;
                if (!reset && cyc >= free_at && (p0_req || p1_req))
                    w = (p0_req && p1_req) ? (last ? 0 : 1) : (p0_req ? 0 : 1);
                xwe    = (w == 0) ? p0_we    : ((w == 1) ? p1_we    : 1'b0);
                xaddr  = (w == 0) ? p0_addr  : ((w == 1) ? p1_addr  : 32'h0);
                xwdata = (w == 0) ? p0_wdata : ((w == 1) ? p1_wdata : 32'h0);
                if (done_cyc == cyc && !done_we) mrd[done_port] = rd_val;

                check(g, "p0_gnt",    32'(p0_gnt),  32'(w == 0));
                check(g, "p1_gnt",    32'(p1_gnt),  32'(w == 1));
                check(g, "mem_en",    32'(mem_en),  32'(w >= 0));
                check(g, "mem_we",    32'(mem_we),  32'(xwe));
                check(g, "mem_addr",  mem_addr,     xaddr);
                check(g, "mem_wdata", mem_wdata,    xwdata);
                check(g, "p0_done",   32'(p0_done), 32'(done_cyc == cyc && done_port == 0));
                check(g, "p1_done",   32'(p1_done), 32'(done_cyc == cyc && done_port == 1));
                check(g, "p0_rdata",  p0_rdata,     mrd[0]);
                check(g, "p1_rdata",  p1_rdata,     mrd[1]);

                if (p0_gnt || p1_gnt) begin
                    ngnt[p1_gnt ? 1 : 0]++;
                    gnt_o[p1_gnt ? 1 : 0] = cyc;
                    g_seen[p1_gnt ? 1 : 0] = 1'b1;
                    gq.push_back(p1_gnt ? 1 : 0);
                    gc.push_back(cyc);
                    g_addr  = mem_addr;
                    g_we    = mem_we;
                    g_wdata = mem_wdata;
                end
                if (p0_done) begin ndone[0]++; done_o[0] = cyc; end
                if (p1_done) begin ndone[1]++; done_o[1] = cyc; end

                if (reset) begin
                    free_at   = cyc + 1;
                    done_cyc  = -100;
                    issue_cyc = -100;
                    last      = 1'b1;
                    mrd[0]    = '0;
                    mrd[1]    = '0;
                end else if (w >= 0) begin
                    last      = (w == 1);
                    free_at   = cyc + LAT + 2;
                    done_cyc  = cyc + LAT + 1;
                    done_port = w;
                    done_we   = xwe;
                    rd_val    = next_rd_val;
                    issue_cyc = cyc;
                end
            end
        end

        // Advance one cycle; memory returns rd_val only in the cycle it is valid, noise otherwise.
        task automatic tick();
            @(posedge clk);
            #1;
            if (!hold) begin
                if (g_seen[0]) p0_req = 1'b0;
                if (g_seen[1]) p1_req = 1'b0;
            end
            g_seen[0] = 1'b0;
            g_seen[1] = 1'b0;
            mem_rdata = (cyc == issue_cyc + LAT) ? rd_val : $urandom;
        endtask

        task automatic wait_gnt(input int p);
            int start;
            int n;
            start = ngnt[p];
            n = 0;
            while (ngnt[p] == start && n < 300) begin
                tick();
                n++;
            end
            check(g, "gnt_seen", 32'(ngnt[p] != start), 32'd1);
        endtask

        initial begin : stim
            int d0;
            repeat (3) tick();
            reset = 1'b0;
            tick();
            check(g, "rst_p0_rdata", p0_rdata, 32'h0);
            check(g, "rst_p1_rdata", p1_rdata, 32'h0);

            // Single p0 read.
            next_rd_val = 32'hDEADBEEF;
            p0_we = 1'b0; p0_addr = 32'h10; p0_req = 1'b1;
            wait_gnt(0);
            repeat (LAT + 3) tick();
            check(g, "rd_done_ofs", done_o[0] - gnt_o[0], DONE_OFS);
            check(g, "rd_addr", g_addr, 32'h10);
            check(g, "rd_we", 32'(g_we), 32'd0);
            check(g, "rd_data", p0_rdata, 32'hDEADBEEF);
            check(g, "rd_p1_quiet", ndone[1], 32'd0);

            // Both ports held high from reset: strict alternation starting with p0.
            reset = 1'b1; tick(); reset = 1'b0;
            hold = 1'b1;
            next_rd_val = 32'hA5A50001;
            gq.delete(); gc.delete();
            p0_we = 1'b0; p0_addr = 32'h100; p1_we = 1'b0; p1_addr = 32'h200;
            p0_req = 1'b1; p1_req = 1'b1;
            for (int n = 0; n < 300 && gq.size() < 4; n++) tick();
            p0_req = 1'b0; p1_req = 1'b0; hold = 1'b0;
            check(g, "rr_count", gq.size(), 32'd4);
            for (int k = 0; k < 4; k++) begin
                check(g, "rr_order", (gq.size() > k) ? gq[k] : 9, k % 2);
                if (k > 0) check(g, "rr_space", (gc.size() > k) ? gc[k] - gc[k-1] : 0, SPACE);
            end
            repeat (SPACE) tick();

            // p1 write: write-ack timing, rdata untouched.
            p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h12345678; p1_req = 1'b1;
            wait_gnt(1);
            repeat (LAT + 3) tick();
            check(g, "wr_we", 32'(g_we), 32'd1);
            check(g, "wr_wdata", g_wdata, 32'h12345678);
            check(g, "wr_done_ofs", done_o[1] - gnt_o[1], DONE_OFS);
            check(g, "wr_rdata_kept", p1_rdata, 32'hA5A50001);

            // p0 arrives while p1 is in flight.
            p1_we = 1'b0; p1_addr = 32'h24; p1_req = 1'b1;
            wait_gnt(1);
            p0_we = 1'b0; p0_addr = 32'h30; p0_req = 1'b1;
            wait_gnt(0);
            check(g, "pend_space", gnt_o[0] - gnt_o[1], SPACE);
            repeat (LAT + 3) tick();

            // Reset during a p0 read's wait phase.
            d0 = ndone[0];
            p0_addr = 32'h40; p0_req = 1'b1;
            wait_gnt(0);
            reset = 1'b1; tick(); reset = 1'b0;
            repeat (LAT + 3) tick();
            check(g, "rst_no_done", ndone[0] - d0, 32'd0);
            check(g, "rst_rdata0", p0_rdata, 32'h0);
            check(g, "rst_rdata1", p1_rdata, 32'h0);
            gq.delete();
            p0_req = 1'b1; p1_req = 1'b1;
            for (int n = 0; n < 300 && gq.size() == 0; n++) tick();
            check(g, "rst_first", (gq.size() > 0) ? gq[0] : 9, 32'd0);

            // Randomized traffic with occasional resets and abandoned requests.
            for (int n = 0; n < 2000; n++) begin
                reset = ($urandom_range(199) == 0);
                next_rd_val = $urandom;
                if (!p0_req) begin
                    if ($urandom_range(2) == 0) begin
                        p0_req = 1'b1; p0_we = 1'($urandom_range(1));
                        p0_addr = $urandom; p0_wdata = $urandom;
                    end
                end else if ($urandom_range(40) == 0) p0_req = 1'b0;
                if (!p1_req) begin
                    if ($urandom_range(2) == 0) begin
                        p1_req = 1'b1; p1_we = 1'($urandom_range(1));
                        p1_addr = $urandom; p1_wdata = $urandom;
                    end
                end else if ($urandom_range(40) == 0) p1_req = 1'b0;
                tick();
            end
            reset = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
            repeat (20) tick();
            fin = 1'b1;
        end
    end

    initial begin : finish_ctl
        bit all_fin;
        all_fin = 1'b0;
        for (int i = 0; i < 30000 && !all_fin; i++) begin
            @(posedge clk);
            all_fin = lane[0].fin && lane[1].fin && lane[2].fin;
        end
        check(-1, "lanes_finished", 32'(all_fin), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
